// File: rtl/als_spi_responder.sv
// als_spi_responder: oversampled SPI responder emulating the ambient-light-sensor ADC.
// Optional ALS_FRAME_CHECK_EN adds err_cnt counting aborted and over-clocked frames.
module als_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_ZEROS  = 3,
  parameter int FRAME_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs,
  input  logic       sck,
  input  logic [7:0] sample,
  output logic       sdo,
  output logic       busy,
  output logic       frame_done,
`ifdef ALS_FRAME_CHECK_EN
  output logic [7:0] err_cnt,
`endif
  output logic [7:0] last_sample
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t r_state, w_state;
  // one stage beyond the synchronizer keeps the previous sample for edge detection
  logic [SYNC_STAGES:0] r_ncs_sync, r_sck_sync;
  logic [7:0] r_shift, w_shift, r_last, w_last;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic r_sdo, w_sdo, r_busy, w_busy, r_done, w_done;
  logic w_ncs_fall, w_ncs_rise, w_sck_fall;
  function automatic logic frame_bit(input logic [7:0] v, input logic [CW-1:0] i);
    int k;
    k = int'(i) - LEAD_ZEROS;
    frame_bit = (k >= 0 && k < 8) ? v[3'(7 - k)] : 1'b0;
  endfunction
  assign w_ncs_fall = !r_ncs_sync[SYNC_STAGES-1] && r_ncs_sync[SYNC_STAGES];
  assign w_ncs_rise = r_ncs_sync[SYNC_STAGES-1] && !r_ncs_sync[SYNC_STAGES];
  assign w_sck_fall = !r_sck_sync[SYNC_STAGES-1] && r_sck_sync[SYNC_STAGES];
  assign w_cnt_inc  = r_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ncs_sync <= '1;
      r_sck_sync <= '1;
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sdo      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= '0;
    end else begin
      r_ncs_sync <= {r_ncs_sync[SYNC_STAGES-1:0], ncs};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-1:0], sck};
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_cnt      <= w_cnt;
      r_sdo      <= w_sdo;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_last     <= w_last;
    end
  end
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_cnt   = r_cnt;
    w_sdo   = r_sdo;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_last  = r_last;
    case (r_state)
      IDLE: begin
        w_sdo = 1'b0;
        if (w_ncs_fall) begin
          w_state = SHIFT;
          w_shift = sample;
          w_cnt   = '0;
          w_busy  = 1'b1;
          w_sdo   = frame_bit(sample, '0);
        end
      end
      SHIFT: begin
        if (w_ncs_rise) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_sdo   = 1'b0;
        end else if (w_sck_fall) begin
          w_cnt   = w_cnt_inc;
          w_state = (w_cnt_inc == CW'(FRAME_BITS)) ? HOLD : SHIFT;
          w_sdo   = (w_cnt_inc == CW'(FRAME_BITS)) ? 1'b0 : frame_bit(r_shift, w_cnt_inc);
        end
      end
      HOLD: begin
        w_sdo = 1'b0;
        if (w_ncs_rise) begin
          w_state = IDLE;
          w_done  = 1'b1;
          w_last  = r_shift;
          w_busy  = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
  end
`ifdef ALS_FRAME_CHECK_EN
  logic r_ovf, w_err_hit;
  logic [7:0] r_err;
  // ncs rise outranks a coincident sck fall, so that fall never marks over-clocking
  assign w_err_hit = (r_state == SHIFT && w_ncs_rise) || (r_state == HOLD && w_ncs_rise && r_ovf);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_err <= '0;
    end else begin
      if (r_state == IDLE && w_ncs_fall) r_ovf <= 1'b0;
      else if (r_state == HOLD && w_sck_fall && !w_ncs_rise) r_ovf <= 1'b1;
      if (w_err_hit && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end
  assign err_cnt = r_err;
`endif
  assign sdo         = r_sdo;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign last_sample = r_last;
endmodule

// File: doc/als_spi_responder.md
Name: als_spi_responder

Overview:
- Behavioural/synthesizable emulator of the ambient-light-sensor ADC, acting as the SPI responder side of the sensor link.
- Driven by the same ncs/sck wires the sensor reader produces, it returns a programmable 8-bit sample on sdo.
- Used in board loop-back tests and simulation benches in place of the physical sensor.
- Oversamples ncs/sck on the system clock; no sck-domain logic.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for ncs and sck (minimum 2).
- LEAD_ZEROS, 3, zero bits before the data MSB.
- FRAME_BITS, 16, sck falling edges per complete frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ncs  input  1  chip select from the reader, active low, asynchronous to clk.
- sck  input  1  serial clock from the reader, asynchronous to clk.
- sdo  output 1  serial data to the reader.
- sample  input  8  value to return; captured at frame start.
- busy  output 1  high while a frame is in progress.
- frame_done  output 1  one-cycle pulse on a completed frame.
- last_sample  output 8  value sent in the most recent completed frame.

Behaviour:
- Reset (async, rst=1): sync chains preset to 1 (ncs high, sck high); state IDLE; sdo=0, busy=0, frame_done=0, last_sample=8'h00, bit counter=0.
- Edge detect: uses the last two synchronized samples. Event latency from a pin transition to internal detection is SYNC_STAGES+1 clk.
- Constraint: sck high and low phases must each be ≥ SYNC_STAGES+2 clk.
- Frame word: bits 0..LEAD_ZEROS-1 are 0; the next 8 bits are sample[7:0], MSB first; all remaining bits up to FRAME_BITS-1 are 0.
- States:
  - IDLE: sdo=0. On detected ncs fall, capture sample into shift_reg, set cnt=0, busy=1, sdo=frame bit 0, go to SHIFT.
  - SHIFT: on each detected sck fall, cnt++, and sdo=frame bit cnt (new value) in the same cycle.
    - When cnt reaches FRAME_BITS, drive sdo=0 and go to HOLD.
    - Detected ncs rise before cnt reaches FRAME_BITS is an aborted frame: go to IDLE, busy=0, no frame_done, last_sample unchanged.
  - HOLD: further sck falls are ignored and sdo stays 0. On detected ncs rise: frame_done=1 for one clk, last_sample=captured value, busy=0, go to IDLE.
- Simultaneous detected ncs rise and sck fall in the same clk: ncs rise wins and the sck edge is ignored.
- A detected sck fall while in IDLE is ignored.
- Reset mid-frame forces IDLE immediately. A new frame starts only on an ncs fall detected after reset release. If ncs is already low at release, the synchronizers see 1→0 and a frame starts; this is intended behaviour.
- Changes to sample during a frame do not affect the current frame.

Optional Feature:
- Macro: ALS_FRAME_CHECK_EN.
- Defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments on each aborted frame; saturates at 8'hFF.
  - Also increments once per frame if any sck fall is detected in HOLD (over-clocking).
- Undefined: no err_cnt port; aborted frames are silently dropped. Functional behaviour is otherwise identical.

Test Plan:
- Nominal frame: sample=8'hA5, ncs low, 16 sck periods (8 clk high / 8 clk low), then ncs high.
  - Reader samples on sck rise and gets 0001_0100_1010_0000 (bit0 first).
  - frame_done pulses once; last_sample=8'hA5; busy high for the whole frame.
- Sample change mid-frame: sample=8'hFF at ncs fall, set to 8'h00 after 5 sck edges.
  - Returned data bits are all 1s; last_sample=8'hFF.
- Aborted frame: ncs high after 7 sck falls.
  - No frame_done; last_sample keeps its previous value; busy drops SYNC_STAGES+1 clk after the ncs rise.
  - With ALS_FRAME_CHECK_EN, err_cnt=1.
- Over-clocked frame: 20 sck falls, then ncs high.
  - sdo=0 for edges 16..19; frame_done pulses once.
  - With ALS_FRAME_CHECK_EN, err_cnt increments by exactly 1.
- Reset mid-frame: assert rst after 9 sck falls with ncs held low.
  - sdo=0 and busy=0 immediately.
  - After rst releases with ncs still low, a new frame starts; a full 16-edge frame then returns the current sample correctly.
- Back-to-back frames with 4 clk ncs-high gaps, samples 8'h01, 8'h80, 8'hFF.
  - Each frame returns its own value; exactly three frame_done pulses.
